// File: rtl/seg_scan_if.sv
// Purpose : bundles the host-side load/status handshake and the display drive
//           lines of the seven-segment scan controller.
// Signals : enable, mode, blank_lz, load, num  -> host to controller
//           busy, done, ovf, seg, seg1, an      -> controller to host/display
// Modports: master (host / bench), slave (seg_scan_ctrl)
interface seg_scan_if #(
    parameter int unsigned NUM_W = 32
);
    logic             enable;
    logic             mode;
    logic             blank_lz;
    logic             load;
    logic [NUM_W-1:0] num;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [7:0]       seg;
    logic [7:0]       seg1;
    logic [7:0]       an;

    modport master (
        output enable, mode, blank_lz, load, num,
        input  busy, done, ovf, seg, seg1, an
    );

    modport slave (
        input  enable, mode, blank_lz, load, num,
        output busy, done, ovf, seg, seg1, an
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Purpose : converts a binary value to hex or BCD digits and scans them onto a
//           multiplexed, active-high seven-segment display.
// Ports   : clk  - sole clock, rising edge
//           rst  - asynchronous active-low reset
//           bus  - seg_scan_if.slave (load/num/mode in, busy/done/ovf out,
//                  seg for digits 4..7, seg1 for digits 0..3, one-hot an)
module seg_scan_ctrl #(
    parameter int unsigned DIGITS   = 8,
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned NUM_W    = 32
) (
    input  logic      clk,
    input  logic      rst,
    seg_scan_if.slave bus
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned PSC_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W = $clog2(NUM_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

    state_e           state_q;
    logic [NUM_W-1:0] num_q;
    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] disp_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_acc_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;
    logic [PSC_W-1:0] psc_q;
    logic [2:0]       dig_q;
    logic [2:0]       dig_d;
    logic             act_q;
    logic             act_d;
    logic [7:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;
    logic [7:0]       seg1_q, seg1_d;

    logic [BCD_W-1:0] bcd_adj_c;
    logic [BCD_W-1:0] hex_dig_c;
    logic             hex_ovf_c;
    logic             tick_c;
    logic [4:0]       shamt_c;
    logic [3:0]       nib_c;
    logic             blank_c;
    logic [7:0]       code_c;

    function automatic logic [7:0] seg_code(input logic [3:0] n);
        case (n)
            4'h0: return 8'hfc;
            4'h1: return 8'h60;
            4'h2: return 8'hda;
            4'h3: return 8'hf2;
            4'h4: return 8'h66;
            4'h5: return 8'hb6;
            4'h6: return 8'hbe;
            4'h7: return 8'he0;
            4'h8: return 8'hfe;
            4'h9: return 8'hf6;
            4'ha: return 8'hee;
            4'hb: return 8'h3e;
            4'hc: return 8'h9c;
            4'hd: return 8'h7a;
            4'he: return 8'h9e;
            4'hf: return 8'h8e;
        endcase
    endfunction

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj_c = bcd_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Hex path: low DIGITS nibbles are shown, anything above them is overflow.
    assign hex_dig_c = BCD_W'(64'(bus.num));
    assign hex_ovf_c = |(64'(bus.num) >> BCD_W);

    // Converter FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            num_q     <= '0;
            bcd_q     <= '0;
            disp_q    <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.load) begin
                        busy_q <= 1'b1;
                        if (bus.mode) begin
                            state_q   <= S_SHIFT;
                            num_q     <= bus.num;
                            bcd_q     <= '0;
                            cnt_q     <= CNT_W'(NUM_W);
                            ovf_acc_q <= 1'b0;
                        end else begin
                            state_q   <= S_DONE;
                            bcd_q     <= hex_dig_c;
                            ovf_acc_q <= hex_ovf_c;
                        end
                    end
                end
                S_SHIFT: begin
                    bcd_q <= {bcd_adj_c[BCD_W-2:0], num_q[NUM_W-1]};
                    num_q <= num_q << 1;
                    cnt_q <= cnt_q - CNT_W'(1);
                    // A 1 leaving the top nibble means the value needs another digit.
                    if (bcd_adj_c[BCD_W-1]) begin
                        ovf_acc_q <= 1'b1;
                    end
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    disp_q  <= bcd_q;
                    ovf_q   <= ovf_acc_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tick_c = (psc_q == PSC_W'(SCAN_DIV - 1));

    // Digit index: the first tick after reset lights digit 0, later ticks advance.
    always_comb begin
        act_d = act_q | tick_c;
        dig_d = dig_q;
        if (tick_c && act_q) begin
            dig_d = (dig_q == 3'(DIGITS - 1)) ? 3'd0 : dig_q + 3'd1;
        end
    end

    // Segment code of the digit being driven next cycle, from the live display register.
    always_comb begin
        shamt_c = {dig_d, 2'b00};
        nib_c   = 4'(disp_q >> shamt_c);
        blank_c = bus.blank_lz && (dig_d != 3'd0) && ((disp_q >> shamt_c) == '0);
        if (ovf_q) begin
            code_c = 8'h02;
        end else if (blank_c) begin
            code_c = 8'h00;
        end else begin
            code_c = seg_code(nib_c);
        end
        an_d   = '0;
        seg_d  = '0;
        seg1_d = '0;
        if (bus.enable && act_d) begin
            an_d = 8'b1 << dig_d;
            if (dig_d < 3'd4) begin
                seg1_d = code_c;
            end else begin
                seg_d = code_c;
            end
        end
    end

    // Scan prescaler and registered display drive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            psc_q  <= '0;
            dig_q  <= '0;
            act_q  <= 1'b0;
            an_q   <= '0;
            seg_q  <= '0;
            seg1_q <= '0;
        end else begin
            psc_q  <= tick_c ? '0 : psc_q + PSC_W'(1);
            dig_q  <= dig_d;
            act_q  <= act_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            seg1_q <= seg1_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;
    assign bus.an   = an_q;
    assign bus.seg  = seg_q;
    assign bus.seg1 = seg1_q;
endmodule
